// File: rtl/i2c_txn_scheduler.sv
// rtl/i2c_txn_scheduler.sv - round-robin two-requester single-byte I2C master sequencer
module i2c_txn_scheduler #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       rw0,
  input  logic       rw1,
  input  logic [6:0] addr0,
  input  logic [6:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic [1:0] gnt,
  output logic       busy,
  output logic [1:0] done,
  output logic       nack,
  output logic [7:0] rdata,
  output logic       scl,
  inout  wire        sda
);

  localparam int BIT_CYC = 4 * CLK_DIV;
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int FW = $clog2(BIT_CYC + 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(CLK_DIV - 1);
  localparam logic [FW-1:0] FREE_MAX = FW'(BIT_CYC);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ADDR, S_ACK1, S_DATA, S_ACK2, S_STOP
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cyc, cyc_n;
  logic [1:0]    q, q_n;
  logic [2:0]    bit_cnt, bit_n;
  logic [FW-1:0] free_cnt;
  logic          last, owner;
  logic          lat_rw;
  logic [6:0]    lat_addr;
  logic [7:0]    lat_wdata, shreg;
  logic          sda_oe, scl_n, sda_oe_n;
  logic          grant, win, bit_end, sample_now, sda_in;
  logic [7:0]    addr_byte;

  assign sda        = sda_oe ? 1'b0 : 1'bz;
  assign sda_in     = sda;
  assign bit_end    = (cyc == CYC_LAST) && (q == 2'd3);
  assign sample_now = (cyc == CYC_LAST) && (q == 2'd2);
  assign addr_byte  = {lat_addr, lat_rw};
  assign grant      = (state == S_IDLE) && (req != 2'b00) && (free_cnt == FREE_MAX);
  assign win        = (req == 2'b11) ? ~last : req[1];

  always_comb begin
    state_n = state;
    cyc_n   = '0;
    q_n     = 2'd0;
    bit_n   = bit_cnt;
    if (state != S_IDLE) begin
      cyc_n = (cyc == CYC_LAST) ? '0 : cyc + 1'b1;
      q_n   = (cyc == CYC_LAST) ? q + 2'd1 : q;
    end
    case (state)
      S_IDLE:  if (grant) state_n = S_START;
      S_START: if (bit_end) begin state_n = S_ADDR; bit_n = 3'd7; end
      S_ADDR:
        if (bit_end) begin
          if (bit_cnt == 3'd0) state_n = S_ACK1;
          else                 bit_n = bit_cnt - 3'd1;
        end
      S_ACK1:
        if (bit_end) begin
          if (nack) state_n = S_STOP;
          else begin state_n = S_DATA; bit_n = 3'd7; end
        end
      S_DATA:
        if (bit_end) begin
          if (bit_cnt == 3'd0) state_n = S_ACK2;
          else                 bit_n = bit_cnt - 3'd1;
        end
      S_ACK2:  if (bit_end) state_n = S_STOP;
      S_STOP:  if (bit_end) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Pin levels are derived from the next state so the registered pins line up with it.
  always_comb begin
    scl_n    = 1'b1;
    sda_oe_n = 1'b0;
    case (state_n)
      S_START: sda_oe_n = q_n[1];
      S_ADDR: begin
        scl_n    = q_n[1];
        sda_oe_n = ~addr_byte[bit_n];
      end
      S_ACK1, S_ACK2: scl_n = q_n[1];
      S_DATA: begin
        scl_n    = q_n[1];
        sda_oe_n = ~lat_rw & ~lat_wdata[bit_n];
      end
      S_STOP: begin
        scl_n    = (q_n != 2'd0);
        sda_oe_n = ~q_n[1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cyc       <= '0;
      q         <= 2'd0;
      bit_cnt   <= 3'd7;
      free_cnt  <= FREE_MAX;
      last      <= 1'b1;
      owner     <= 1'b0;
      lat_rw    <= 1'b0;
      lat_addr  <= 7'd0;
      lat_wdata <= 8'd0;
      shreg     <= 8'd0;
      nack      <= 1'b0;
      rdata     <= 8'd0;
      done      <= 2'b00;
      gnt       <= 2'b00;
      busy      <= 1'b0;
      scl       <= 1'b1;
      sda_oe    <= 1'b0;
    end else begin
      state   <= state_n;
      cyc     <= cyc_n;
      q       <= q_n;
      bit_cnt <= bit_n;
      scl     <= scl_n;
      sda_oe  <= sda_oe_n;
      busy    <= (state_n != S_IDLE);
      done    <= 2'b00;
      if (state != S_IDLE)          free_cnt <= '0;
      else if (free_cnt != FREE_MAX) free_cnt <= free_cnt + 1'b1;
      if (done != 2'b00) gnt <= 2'b00;
      if (grant) begin
        owner     <= win;
        last      <= win;
        gnt       <= win ? 2'b10 : 2'b01;
        lat_rw    <= win ? rw1 : rw0;
        lat_addr  <= win ? addr1 : addr0;
        lat_wdata <= win ? wdata1 : wdata0;
        nack      <= 1'b0;
      end
      if (sample_now) begin
        case (state)
          S_ACK1:  nack <= sda_in;
          S_DATA:  if (lat_rw) shreg <= {shreg[6:0], sda_in};
          S_ACK2:  if (!lat_rw && sda_in) nack <= 1'b1;
          default: ;
        endcase
      end
      if (state == S_STOP && bit_end) begin
        done <= owner ? 2'b10 : 2'b01;
        if (lat_rw && !nack) rdata <= shreg;
      end
    end
  end

endmodule

// File: tb/tb_i2c_txn_scheduler.sv
// tb/tb_i2c_txn_scheduler.sv - randomized bench with behavioural I2C slave and arbitration model
module tb_i2c_txn_scheduler;
  localparam int CD  = 4;
  localparam int BIT = 4 * CD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req = 2'b00;
  logic       rw0 = 1'b0, rw1 = 1'b0;
  logic [6:0] addr0 = 7'd0, addr1 = 7'd0;
  logic [7:0] wdata0 = 8'd0, wdata1 = 8'd0;
  logic [1:0] gnt, done;
  logic       busy, nack, scl;
  logic [7:0] rdata;
  wire        sda;
  logic       sl_pull = 1'b0;

  assign sda = sl_pull ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_txn_scheduler #(.CLK_DIV(CD)) dut (
    .clk(clk), .rst(rst), .req(req),
    .rw0(rw0), .rw1(rw1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt(gnt), .busy(busy), .done(done), .nack(nack), .rdata(rdata),
    .scl(scl), .sda(sda)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int n_cmp = 0, n_mis = 0;
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Behavioural slave at 0x78: bus decoded from scl/sda levels sampled every negedge clk.
  logic [7:0] sl_rd = 8'd0;
  logic       sl_dn = 1'b0;
  logic       prev_scl = 1'b1, prev_sda = 1'b1;
  int         sl_bitn = 0;
  int         scl_rises = 0;
  logic [7:0] sl_abyte = 8'd0, sl_dbyte = 8'd0;
  logic       sl_mack = 1'b0;

  function automatic logic drive_for(input int k);
    logic m, rd;
    m  = (sl_abyte[7:1] == 7'h78);
    rd = sl_abyte[0];
    if (k == 9)              return m;
    if (k >= 10 && k <= 17)  return (m && rd) ? ~sl_rd[17-k] : 1'b0;
    if (k == 18)             return m && !rd && !sl_dn;
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    prev_scl <= scl;
    prev_sda <= sda;
    if (rst) begin
      sl_pull <= 1'b0;
      sl_bitn <= 0;
    end else if (prev_scl && scl && prev_sda && !sda) begin
      sl_bitn <= 0;
      sl_pull <= 1'b0;
    end else if (!prev_scl && scl) begin
      sl_bitn   <= sl_bitn + 1;
      scl_rises <= scl_rises + 1;
      if (sl_bitn < 8)                     sl_abyte <= {sl_abyte[6:0], sda};
      else if (sl_bitn >= 9 && sl_bitn < 17) sl_dbyte <= {sl_dbyte[6:0], sda};
      else if (sl_bitn == 17)              sl_mack  <= sda;
    end else if (prev_scl && !scl) begin
      sl_pull <= drive_for(sl_bitn + 1);
    end
  end

  // Reference model: per-requester parameters, round-robin pointer, last read byte.
  logic       p_rw [2];
  logic [6:0] p_addr [2];
  logic [7:0] p_wd [2];
  logic [7:0] p_rd [2];
  logic       p_dn [2];
  logic       last_g = 1'b1;
  int         last_done = 0;
  logic       have_done = 1'b0;
  logic [7:0] exp_rdata = 8'd0;

  task automatic apply_inputs(input int w);
    if (w == 0) begin rw0 = p_rw[0]; addr0 = p_addr[0]; wdata0 = p_wd[0]; end
    else        begin rw1 = p_rw[1]; addr1 = p_addr[1]; wdata1 = p_wd[1]; end
  endtask

  task automatic load(input int w, input logic rw, input logic [6:0] a,
                      input logic [7:0] wd, input logic [7:0] rd, input logic dn);
    p_rw[w] = rw; p_addr[w] = a; p_wd[w] = wd; p_rd[w] = rd; p_dn[w] = dn;
    apply_inputs(w);
  endtask

  task automatic scramble(input int w);
    if (w == 0) begin rw0 = 1'($urandom); addr0 = 7'($urandom); wdata0 = 8'($urandom); end
    else        begin rw1 = 1'($urandom); addr1 = 7'($urandom); wdata1 = 8'($urandom); end
  endtask

  task automatic serve(input logic [1:0] rel_mask, input logic exact_gap, input logic drop_mid);
    int w, t, gcyc, dcyc, r0;
    logic m;
    logic [1:0] onehot;
    w = (req == 2'b11) ? (last_g ? 0 : 1) : (req[1] ? 1 : 0);
    onehot = (w == 1) ? 2'b10 : 2'b01;
    t = 0;
    while (gnt == 2'b00 && t < 4000) begin @(negedge clk); t++; end
    check_eq("grant_onehot", gnt, onehot);
    if (gnt == 2'b00) return;
    gcyc = cyc_cnt;
    check_eq("busy_at_grant", busy, 1);
    if (have_done) begin
      if (exact_gap) check_eq("gap_exact", gcyc - last_done, BIT + 1);
      else           check_eq("gap_min", (gcyc - last_done) >= BIT + 1, 1);
    end
    last_g = (w == 1);
    sl_rd = p_rd[w];
    sl_dn = p_dn[w];
    r0 = scl_rises;
    scramble(w);
    if (drop_mid) begin
      repeat (4 * BIT) @(negedge clk);
      req[w] = 1'b0;
    end
    t = 0;
    while (done == 2'b00 && t < 4000) begin @(negedge clk); t++; end
    dcyc = cyc_cnt;
    m = (p_addr[w] == 7'h78);
    check_eq("done_onehot", done, onehot);
    check_eq("gnt_at_done", gnt, onehot);
    check_eq("txn_cycles", dcyc - gcyc, m ? 20 * BIT : 11 * BIT);
    check_eq("nack", nack, !m || (!p_rw[w] && p_dn[w]));
    if (m && p_rw[w]) exp_rdata = p_rd[w];
    check_eq("rdata", rdata, exp_rdata);
    check_eq("scl_rises", scl_rises - r0, m ? 19 : 10);
    check_eq("addr_byte_on_bus", sl_abyte, {p_addr[w], p_rw[w]});
    if (m && !p_rw[w]) check_eq("wdata_on_bus", sl_dbyte, p_wd[w]);
    if (m && p_rw[w])  check_eq("master_nack_on_read", sl_mack, 1);
    req = req & ~rel_mask;
    apply_inputs(w);
    last_done = dcyc;
    have_done = 1'b1;
    @(negedge clk);
    check_eq("done_one_cycle", done, 0);
    check_eq("gnt_cleared", gnt, 0);
    check_eq("busy_after_done", busy, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int extra, t;
    logic [1:0] msk;
    logic [6:0] a;

    repeat (3) @(negedge clk);
    check_eq("rst_scl", scl, 1);
    check_eq("rst_sda", sda, 1);
    check_eq("rst_gnt", gnt, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_nack", nack, 0);
    check_eq("rst_rdata", rdata, 0);
    rst = 1'b0;
    @(negedge clk);

    // Simultaneous held requests from a fresh pointer: 0,1,0,1.
    load(0, 1'b0, 7'h78, 8'($urandom), 8'h00, 1'b0);
    load(1, 1'b1, 7'h78, 8'h00, 8'($urandom), 1'b0);
    req = 2'b11;
    serve(2'b00, 1'b0, 1'b0);
    serve(2'b00, 1'b1, 1'b0);
    serve(2'b00, 1'b1, 1'b0);
    serve(2'b11, 1'b1, 1'b0);

    load(0, 1'b0, 7'h78, 8'h5A, 8'h00, 1'b0);
    req = 2'b01;
    serve(2'b01, 1'b0, 1'b0);

    load(1, 1'b1, 7'h78, 8'h00, 8'hCD, 1'b0);
    req = 2'b10;
    serve(2'b10, 1'b0, 1'b0);

    load(0, 1'b0, 7'h22, 8'h99, 8'h00, 1'b0);
    req = 2'b01;
    serve(2'b01, 1'b0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      int w;
      w = $urandom_range(0, 1);
      a = 7'($urandom);
      if (a == 7'h78) a = 7'h22;
      load(w, 1'($urandom), ($urandom_range(0, 3) != 0) ? 7'h78 : a,
           8'($urandom), 8'($urandom), $urandom_range(0, 3) == 0);
      msk = (w == 1) ? 2'b10 : 2'b01;
      req = msk;
      serve(msk, 1'b0, 1'b0);
    end

    // Request withdrawn during ADDR: transaction still finishes, no re-grant.
    load(0, 1'b0, 7'h78, 8'($urandom), 8'h00, 1'b0);
    req = 2'b01;
    serve(2'b01, 1'b0, 1'b1);
    extra = 0;
    repeat (60) begin
      @(negedge clk);
      if (done != 2'b00 || gnt != 2'b00) extra++;
    end
    check_eq("no_second_done", extra, 0);

    // Reset in the middle of DATA bit 3 of a requester-0 write.
    load(0, 1'b0, 7'h78, 8'($urandom), 8'h00, 1'b0);
    req = 2'b01;
    t = 0;
    while (gnt == 2'b00 && t < 4000) begin @(negedge clk); t++; end
    check_eq("rst_test_grant", gnt, 2'b01);
    repeat (14 * BIT + BIT / 2) @(negedge clk);
    check_eq("busy_before_rst", busy, 1);
    rst = 1'b1;
    req = 2'b00;
    @(negedge clk);
    check_eq("midrst_scl", scl, 1);
    check_eq("midrst_sda", sda, 1);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_gnt", gnt, 0);
    check_eq("midrst_done", done, 0);
    repeat (2) @(negedge clk);
    check_eq("midrst_done_held", done, 0);
    rst = 1'b0;
    last_g = 1'b1;
    have_done = 1'b0;
    @(negedge clk);
    load(0, 1'b1, 7'h78, 8'h00, 8'($urandom), 1'b0);
    load(1, 1'b0, 7'h78, 8'($urandom), 8'h00, 1'b0);
    req = 2'b11;
    serve(2'b00, 1'b0, 1'b0);
    serve(2'b11, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
